// File: rtl/wave_generator.sv
// wave_generator: four-shape periodic waveform source (saw, ramp-down,
// triangle, square) built on one phase counter with a run-time step divider.
// Drives an R2R DAC code and a PWM output whose duty tracks that code.
// Mode and divider are sampled only when entering RUN and when the phase
// wraps, so shape and rate changes always land on a period boundary.
module wave_generator #(
  parameter int WIDTH       = 8,
  parameter int DIV_W       = 24,
  parameter int DEFAULT_DIV = 390625
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] step_div,
  output logic [WIDTH-1:0] dac_out,
  output logic             pwm_out,
  output logic             period_start,
  output logic [1:0]       active_mode
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] MAX_CODE = '1;
  localparam logic [DIV_W-1:0] DEF_DIV  = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE_DIV  = DIV_W'(1);

  localparam logic [1:0] MODE_SAW  = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_TRI  = 2'b10;
  localparam logic [1:0] MODE_SQR  = 2'b11;

  state_t state;
  state_t state_next;

  logic             start_run;
  logic             stop_run;
  logic             running;

  logic [DIV_W-1:0] eff_div;
  logic [DIV_W-1:0] div_lat;
  logic [DIV_W-1:0] div_cmp;
  logic [DIV_W-1:0] divcnt;
  logic             div_done;
  logic             tick;

  logic [WIDTH-1:0] phase;
  logic             phase_wrap;
  logic             wrapped;
  logic [1:0]       mode_lat;

  logic [WIDTH-1:0] pwm_cnt;
  logic [WIDTH-1:0] wave_code;
  logic [WIDTH-1:0] tri_code;

  // Resolve the divider actually used; zero means "use the built-in default".
  always_comb begin
    eff_div = step_div;
    if (step_div == '0) begin
      eff_div = DEF_DIV;
    end
  end

  // Divider terminal count; on a wrap cycle the freshly latched divider
  // governs the first step of the new period, so compare against it.
  always_comb begin
    running    = (state == RUN) && enable;
    phase_wrap = running && tick && (phase == MAX_CODE);
    div_cmp    = phase_wrap ? eff_div : div_lat;
    div_done   = (divcnt >= (div_cmp - ONE_DIV));
  end

  // State register for the IDLE/RUN controller.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: enable starts a run, dropping enable ends it at once.
  always_comb begin
    state_next = state;
    start_run  = 1'b0;
    stop_run   = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_next = RUN;
          start_run  = 1'b1;
        end
      end
      RUN: begin
        if (!enable) begin
          state_next = IDLE;
          stop_run   = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Divider, phase counter, boundary latches and PWM counter.
  // The entry cycle counts as divider count 0 so the first step of a run
  // lasts exactly eff_div clocks, the same as every later step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      divcnt   <= '0;
      tick     <= 1'b0;
      phase    <= '0;
      div_lat  <= '0;
      mode_lat <= '0;
      wrapped  <= 1'b0;
      pwm_cnt  <= '0;
    end else if (start_run) begin
      divcnt   <= (eff_div == ONE_DIV) ? '0 : ONE_DIV;
      tick     <= (eff_div == ONE_DIV);
      phase    <= '0;
      div_lat  <= eff_div;
      mode_lat <= mode;
      wrapped  <= 1'b0;
      pwm_cnt  <= '0;
    end else if (running) begin
      if (div_done) begin
        divcnt <= '0;
        tick   <= 1'b1;
      end else begin
        divcnt <= divcnt + ONE_DIV;
        tick   <= 1'b0;
      end
      if (tick) begin
        phase <= phase + 1'b1;
      end
      if (phase_wrap) begin
        div_lat  <= eff_div;
        mode_lat <= mode;
      end
      wrapped <= phase_wrap;
      pwm_cnt <= pwm_cnt + 1'b1;
    end else begin
      divcnt  <= '0;
      tick    <= 1'b0;
      phase   <= '0;
      wrapped <= 1'b0;
      pwm_cnt <= '0;
    end
  end

  // Phase-to-code mapping for the latched mode.
  always_comb begin
    tri_code = {phase[WIDTH-2:0], 1'b0};
    if (phase[WIDTH-1]) begin
      tri_code = ~{phase[WIDTH-2:0], 1'b0};
    end
    wave_code = phase;
    case (mode_lat)
      MODE_SAW:  wave_code = phase;
      MODE_DOWN: wave_code = MAX_CODE - phase;
      MODE_TRI:  wave_code = tri_code;
      MODE_SQR:  wave_code = {WIDTH{phase[WIDTH-1]}};
      default:   wave_code = phase;
    endcase
  end

  // Registered outputs; all forced low whenever the controller is idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dac_out      <= '0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
      active_mode  <= '0;
    end else if (state == RUN) begin
      dac_out      <= wave_code;
      pwm_out      <= (pwm_cnt < dac_out);
      period_start <= wrapped;
      active_mode  <= mode_lat;
    end else begin
      dac_out      <= '0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
      active_mode  <= '0;
    end
  end

endmodule

// File: tb/tb_wave_generator.sv
// tb_wave_generator: directed bench for wave_generator with hand-derived
// expected codes, step timing, period_start placement and PWM duty.
// The run is entered at a falling edge; "k" counts falling edges after that,
// so dac_out at step k shows the phase held after the (k-1)th rising edge.
module tb_wave_generator;

  localparam int WIDTH = 8;
  localparam int DIV_W = 24;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic [DIV_W-1:0] step_div = '0;
  logic [WIDTH-1:0] dac_out;
  logic             pwm_out;
  logic             period_start;
  logic [1:0]       active_mode;

  int vectors = 0;
  int miscompares = 0;

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  wave_generator #(
    .WIDTH(WIDTH),
    .DIV_W(DIV_W),
    .DEFAULT_DIV(10)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .mode(mode),
    .step_div(step_div),
    .dac_out(dac_out),
    .pwm_out(pwm_out),
    .period_start(period_start),
    .active_mode(active_mode)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)",
               tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [1:0] m,
                               input logic [DIV_W-1:0] div);
    enable   = en;
    mode     = m;
    step_div = div;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_dac"}, 32'(dac_out), 32'd0);
    checkOutput({tag, "_pwm"}, 32'(pwm_out), 32'd0);
    checkOutput({tag, "_pstart"}, 32'(period_start), 32'd0);
    checkOutput({tag, "_amode"}, 32'(active_mode), 32'd0);
  endtask

  // Drop enable, confirm everything is low two cycles later, then rest.
  task automatic stopRun(input string tag);
    @(negedge clk);
    applyStimulus(1'b0, mode, step_div);
    repeat (2) @(negedge clk);
    checkIdle(tag);
    repeat (2) @(negedge clk);
  endtask

  function automatic int triExp(input int p);
    return (p < 128) ? 2 * p : 255 - 2 * (p - 128);
  endfunction

  initial begin
    int exp_dac;
    int p;
    int high_count;

    $display("[TB] start");

    // Reset and idle behaviour.
    repeat (3) @(negedge clk);
    checkIdle("in_reset");
    reset_n = 1'b1;
    repeat (100) @(negedge clk);
    checkIdle("idle");

    // Saw, 4 clocks per step, one full period and the wrap.
    applyStimulus(1'b1, 2'b00, 24'd4);
    for (int k = 1; k <= 1027; k++) begin
      @(negedge clk);
      exp_dac = (k < 2) ? 0 : ((k - 2) / 4) % 256;
      checkOutput("saw_dac", 32'(dac_out), 32'(exp_dac));
      if (k <= 3 || k >= 1024) begin
        checkOutput("saw_pstart", 32'(period_start), (k == 1026) ? 32'd1 : 32'd0);
      end
    end
    stopRun("saw_stop");

    // Triangle at one clock per step.
    @(negedge clk);
    applyStimulus(1'b1, 2'b10, 24'd1);
    for (int k = 1; k <= 259; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checkOutput("tri_first", 32'(dac_out), 32'd0);
      end else if (k <= 257) begin
        checkOutput("tri_dac", 32'(dac_out), 32'(triExp(k - 2)));
      end else if (k == 258) begin
        checkOutput("tri_wrap_dac", 32'(dac_out), 32'd0);
      end
      if (k == 2) begin
        checkOutput("tri_amode", 32'(active_mode), 32'd2);
      end
      checkOutput("tri_pstart", 32'(period_start), (k == 258) ? 32'd1 : 32'd0);
    end
    stopRun("tri_stop");

    // Ramp-down at one clock per step.
    @(negedge clk);
    applyStimulus(1'b1, 2'b01, 24'd1);
    for (int k = 1; k <= 258; k++) begin
      @(negedge clk);
      exp_dac = (k < 2) ? 0 : (k <= 257) ? 255 - (k - 2) : 255;
      checkOutput("down_dac", 32'(dac_out), 32'(exp_dac));
    end
    stopRun("down_stop");

    // Square at one clock per step.
    @(negedge clk);
    applyStimulus(1'b1, 2'b11, 24'd1);
    for (int k = 1; k <= 258; k++) begin
      @(negedge clk);
      exp_dac = (k < 2) ? 0 : (k <= 257) ? (((k - 2) < 128) ? 0 : 255) : 0;
      checkOutput("sqr_dac", 32'(dac_out), 32'(exp_dac));
    end
    stopRun("sqr_stop");

    // Saw/4 switched to square/2 at phase 100; takes effect at the wrap.
    @(negedge clk);
    applyStimulus(1'b1, 2'b00, 24'd4);
    for (int k = 1; k <= 1290; k++) begin
      @(negedge clk);
      if (k < 2) begin
        exp_dac = 0;
      end else if (k <= 1025) begin
        exp_dac = (k - 2) / 4;
      end else begin
        p = (k - 1026) / 2;
        exp_dac = (p < 128) ? 0 : 255;
      end
      checkOutput("bnd_dac", 32'(dac_out), 32'(exp_dac));
      if (k >= 1020 && k <= 1030) begin
        checkOutput("bnd_amode", 32'(active_mode), (k >= 1026) ? 32'd3 : 32'd0);
        checkOutput("bnd_pstart", 32'(period_start), (k == 1026) ? 32'd1 : 32'd0);
      end
      if (k == 401) begin
        applyStimulus(1'b1, 2'b11, 24'd2);
      end
    end
    stopRun("bnd_stop");

    // step_div = 0 falls back to the default divider (10 in this bench).
    @(negedge clk);
    applyStimulus(1'b1, 2'b01, 24'd0);
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      exp_dac = (k < 2) ? 0 : 255 - (k - 2) / 10;
      checkOutput("def_dac", 32'(dac_out), 32'(exp_dac));
    end
    checkOutput("def_amode", 32'(active_mode), 32'd1);

    // Asynchronous reset mid-run, then restart from a fresh entry.
    #2 reset_n = 1'b0;
    #1 checkIdle("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      exp_dac = (k < 2) ? 0 : 255 - (k - 2) / 10;
      checkOutput("rst_restart_dac", 32'(dac_out), 32'(exp_dac));
    end
    stopRun("rst_stop");

    // PWM duty with dac_out parked at 64 (triangle phase 32, 600 clk steps).
    @(negedge clk);
    applyStimulus(1'b1, 2'b10, 24'd600);
    high_count = 0;
    for (int k = 1; k <= 19555; k++) begin
      @(negedge clk);
      if (k == 19300) begin
        checkOutput("pwm_level", 32'(dac_out), 32'd64);
      end
      if (k >= 19300) begin
        high_count += int'(pwm_out);
      end
    end
    checkOutput("pwm_duty", 32'(high_count), 32'd64);
    applyStimulus(1'b0, 2'b10, 24'd600);
    repeat (2) @(negedge clk);
    checkIdle("pwm_disable");
    repeat (3) @(negedge clk);

    // Re-enable: restart at code 0 with no period_start on entry.
    applyStimulus(1'b1, 2'b00, 24'd4);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      exp_dac = (k < 2) ? 0 : (k - 2) / 4;
      checkOutput("reen_dac", 32'(dac_out), 32'(exp_dac));
      checkOutput("reen_pstart", 32'(period_start), 32'd0);
    end
    stopRun("final_stop");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wave_generator.md
Name: wave_generator

Overview:
- Parametrised successor to the single-mode sawtooth generator.
- Produces four selectable periodic waveforms from one phase counter: saw, ramp-down, triangle and square.
- Step rate is programmable at run time. Mode and rate changes apply glitch-free at period boundaries.
- Drives an R2R DAC bus directly and an internal PWM whose duty follows the DAC code. Sits between the control/register block and the board DAC/PWM pins.

Parameters:
- WIDTH, 8, DAC/phase/PWM resolution in bits; one period = 2^WIDTH steps.
- DIV_W, 24, width of the run-time step divider input.
- DEFAULT_DIV, 390625, clocks per step used when step_div = 0 (1 Hz at 100 MHz, WIDTH=8).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  run when high; clears and holds outputs when low.
- mode  in  2  00 saw, 01 ramp-down, 10 triangle, 11 square.
- step_div  in  DIV_W  clocks per phase step; 0 selects DEFAULT_DIV.
- dac_out  out  WIDTH  waveform code to the R2R ladder.
- pwm_out  out  1  PWM with duty = dac_out / 2^WIDTH.
- period_start  out  1  one-cycle pulse when phase wraps to 0.
- active_mode  out  2  mode currently being generated.

Behaviour:
- Reset (reset_n low, async): all outputs and internal state clear.
  - Clears divcnt, phase, pwm_cnt, tick, dac_out, pwm_out, period_start and active_mode.
  - Clears the internal state register, which returns to IDLE.
- State machine:
  - IDLE: outputs 0. On enable=1, latch mode into active_mode and latch the effective divider, then go to RUN.
  - RUN: on enable=0, go to IDLE next cycle. That cycle clears divcnt, phase, pwm_cnt and tick; dac_out, pwm_out and period_start are 0 one cycle later.
- Effective divider: eff_div = (step_div == 0) ? DEFAULT_DIV : step_div. eff_div = 1 is legal and gives a tick every cycle.
- Divider:
  - divcnt counts 0..eff_div-1 in RUN.
  - tick is registered and high for the one cycle after divcnt == eff_div-1.
  - Step period is exactly eff_div clocks.
- Phase:
  - On tick, phase <= phase + 1, wrapping naturally from 2^WIDTH-1 to 0.
  - On that wrap, re-latch mode and eff_div from the current inputs. Mid-period input changes are ignored until the wrap.
- period_start: high for exactly one cycle, the cycle after phase becomes 0 via a wrap. Not asserted on entry from IDLE.
- Waveform mapping (registered; dac_out lags phase by 1 cycle). M = 2^WIDTH-1, L = phase[WIDTH-2:0]:
  - saw: phase.
  - ramp-down: M - phase.
  - triangle: phase MSB = 0 gives {L,0}; MSB = 1 gives ~{L,0}. Sequence for WIDTH=8: 0,2,...,254,255,253,...,1.
  - square: phase MSB replicated across all WIDTH bits (0 for the first half-period, M for the second).
- PWM:
  - pwm_cnt is a free-running WIDTH-bit counter in RUN.
  - pwm_out is registered as (pwm_cnt < dac_out).
  - dac_out = 0 gives a constant low; dac_out = M gives high 255 of 256 cycles.
- Simultaneous events:
  - enable falling on a tick cycle: disable wins and phase does not advance.
  - step_div changing on the wrap cycle: the value present on that cycle is latched.
- Reset mid-operation: immediate clear. Restart after release requires an IDLE->RUN entry with fresh latches.

Test Plan:
- Reset/idle: reset_n=0 then 1, enable=0 for 100 cycles -> dac_out=0, pwm_out=0, period_start=0, active_mode=0.
- Saw timing: WIDTH=8, step_div=4, mode=00, enable=1 -> dac_out increments every 4 clocks, 0..255. Wrap occurs after 1024 clocks, with period_start high for 1 cycle when dac_out returns to 0.
- Triangle/ramp-down/square codes: step_div=1 -> triangle gives 0,2,4,...,254,255,253,...,1. Ramp-down gives 255..0. Square gives 128 steps of 0 then 128 steps of 255.
- Boundary-synchronised change: in saw, change mode to 11 and step_div 4->2 at phase=100 -> saw and 4-clock steps continue to 255. From phase 0 onward the output is square with 2-clock steps, and active_mode=11 from the same cycle.
- step_div=0: run 3 steps -> tick spacing = DEFAULT_DIV (use a reduced DEFAULT_DIV=10 in simulation).
- PWM and disable: hold dac_out=64 (step_div large) -> pwm_out high 64 of every 256 clocks. Drop enable -> all outputs 0 within 2 cycles. Re-enable -> dac_out restarts at 0 with no period_start pulse.
